// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, parity types and state encoding
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [4:0] DEFAULT_PRESCALE = 5'd16;

    // Frame phases, shared by the transmitter and the receiver
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - producer-facing handshake and serial line of the UART transmitter
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [4:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - parity bit of the latched byte
module uart_tx_parity_calc
    import uart_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity is the plain XOR reduction; odd parity is its inverse
    assign par_bit = (par_typ == PAR_EVEN) ? (^data) : ~(^data);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, stop
module uart_tx
    import uart_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [4:0]            ps_last_q, ps_last_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  par_bit;
    logic                  bit_done;
    logic [2:0]            idx_inc;

    uart_tx_parity_calc u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // The shadow holds Prescale-1, so a bit ends when the counter reaches it
    assign bit_done = (cnt_q == ps_last_q);
    assign idx_inc  = idx_q + 3'd1;

    // Next state, counters, shadow and the line value for the coming cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ps_last_d = ps_last_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = 5'd0;
                idx_d  = 3'd0;
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    ps_last_d = (bus.Prescale == 5'd0) ? 5'd0 : (bus.Prescale - 5'd1);
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + 5'd1;
                if (bit_done) begin
                    cnt_d   = 5'd0;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 5'd1;
                if (bit_done) begin
                    cnt_d = 5'd0;
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = data_q[idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_q + 5'd1;
                if (bit_done) begin
                    cnt_d   = 5'd0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + 5'd1;
                if (bit_done) begin
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                idx_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, shadow and registered outputs; reset forces an idle line at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            idx_q     <= 3'd0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            ps_last_q <= 5'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            ps_last_q <= ps_last_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;
    import uart_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_tx_if u_if ();

    uart_tx dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    always #5 CLK = ~CLK;

    int   n_asserts = 0;
    int   n_fails   = 0;
    int   last_busy = 0;
    logic exp_bits[$];
    logic got_bits[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line model: the ordered list of bit values a frame puts on the wire
    function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pe) exp_bits.push_back((^d) ^ pt);
        exp_bits.push_back(1'b1);
    endfunction

    function automatic logic [31:0] pack_got();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < got_bits.size() && i < 32; i++) v[i] = got_bits[i];
        return v;
    endfunction

    // Present a request and let the accept edge happen; inputs are scrambled afterwards
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [4:0] ps, input logic hold);
        @(negedge CLK);
        u_if.P_DATA     = d;
        u_if.PAR_EN     = pe;
        u_if.PAR_TYP    = pt;
        u_if.Prescale   = ps;
        u_if.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        u_if.P_DATA     = 8'($urandom);
        u_if.PAR_EN     = 1'($urandom);
        u_if.PAR_TYP    = 1'($urandom);
        u_if.Prescale   = 5'($urandom);
        u_if.Data_Valid = hold;
        @(negedge CLK);
    endtask

    // Called at the first falling edge after accept; ends at the first idle cycle
    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                               input logic pt, input int ps);
        int pse, len, bad_tx, bad_busy, busy_cyc;
        logic [7:0] rx;
        pse = (ps == 0) ? 1 : ps;
        build_frame(d, pe, pt);
        len = exp_bits.size() * pse;
        bad_tx = 0; bad_busy = 0; busy_cyc = 0;
        got_bits = {};
        for (int c = 0; c < len; c++) begin
            if (u_if.TX_OUT !== exp_bits[c / pse]) bad_tx++;
            if (u_if.Busy === 1'b1) busy_cyc++; else bad_busy++;
            if ((c % pse) == (pse / 2)) got_bits.push_back(u_if.TX_OUT);
            @(negedge CLK);
        end
        rx = '0;
        for (int i = 0; i < 8; i++) rx[i] = got_bits[i + 1];
        last_busy = busy_cyc;
        check({tag, ".tx_wave_errs"}, bad_tx, 0);
        check({tag, ".busy_drops"}, bad_busy, 0);
        check({tag, ".busy_len"}, busy_cyc, len);
        check({tag, ".rx_byte"}, rx, d);
        check({tag, ".idle_tx"}, u_if.TX_OUT, 1);
        check({tag, ".idle_busy"}, u_if.Busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [7:0] rd;
        logic       rpe, rpt;
        logic [4:0] rps;

        u_if.P_DATA     = 8'h00;
        u_if.Data_Valid = 1'b0;
        u_if.PAR_EN     = 1'b0;
        u_if.PAR_TYP    = 1'b0;
        u_if.Prescale   = 5'd1;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("rst_tx", u_if.TX_OUT, 1);
            check("rst_busy", u_if.Busy, 0);
            u_if.P_DATA     = 8'($urandom);
            u_if.Data_Valid = 1'($urandom);
            u_if.PAR_EN     = 1'($urandom);
            u_if.PAR_TYP    = 1'($urandom);
            u_if.Prescale   = 5'($urandom);
        end
        @(negedge CLK);
        u_if.Data_Valid = 1'b0;
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (u_if.TX_OUT !== 1'b1 || u_if.Busy !== 1'b0) bad++;
        end
        check("post_rst_idle_errs", bad, 0);

        // Default prescale, odd parity, 0x55
        start_frame(8'h55, 1'b1, PAR_ODD, DEFAULT_PRESCALE, 1'b0);
        check_frame("f55", 8'h55, 1'b1, PAR_ODD, 16);
        check("f55.bit_seq", pack_got(), 32'b110_1010_1010);
        check("f55.busy_176", last_busy, 176);

        // Prescale 8, no parity, 0x81
        start_frame(8'h81, 1'b0, 1'b0, 5'd8, 1'b0);
        check_frame("f81", 8'h81, 1'b0, 1'b0, 8);
        check("f81.bit_seq", pack_got(), 32'b11_0000_0010);
        check("f81.busy_80", last_busy, 80);

        // Parity type on 0x07
        start_frame(8'h07, 1'b1, PAR_EVEN, 5'd3, 1'b0);
        check_frame("p_even", 8'h07, 1'b1, PAR_EVEN, 3);
        check("p_even.par_bit", got_bits[9], 1);
        start_frame(8'h07, 1'b1, PAR_ODD, 5'd3, 1'b0);
        check_frame("p_odd", 8'h07, 1'b1, PAR_ODD, 3);
        check("p_odd.par_bit", got_bits[9], 0);

        // Prescale 1 and prescale 0 both give one bit per clock
        start_frame(8'hC6, 1'b1, PAR_EVEN, 5'd1, 1'b0);
        check_frame("ps1", 8'hC6, 1'b1, PAR_EVEN, 1);
        check("ps1.busy_11", last_busy, 11);
        start_frame(8'h39, 1'b0, 1'b0, 5'd0, 1'b0);
        check_frame("ps0", 8'h39, 1'b0, 1'b0, 0);
        check("ps0.busy_10", last_busy, 10);

        // Back-to-back with Data_Valid held and P_DATA changed mid-frame
        start_frame(8'hA3, 1'b1, PAR_EVEN, 5'd2, 1'b1);
        u_if.P_DATA   = 8'h3C;
        u_if.PAR_EN   = 1'b1;
        u_if.PAR_TYP  = PAR_EVEN;
        u_if.Prescale = 5'd2;
        check_frame("b2b_a3", 8'hA3, 1'b1, PAR_EVEN, 2);
        @(posedge CLK);
        #1;
        u_if.Data_Valid = 1'b0;
        @(negedge CLK);
        check_frame("b2b_3c", 8'h3C, 1'b1, PAR_EVEN, 2);

        // Random frames
        for (int n = 0; n < 8; n++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rps = 5'($urandom_range(0, 6));
            start_frame(rd, rpe, rpt, rps, 1'b0);
            check_frame($sformatf("rnd%0d", n), rd, rpe, rpt, int'(rps));
        end

        // Reset during data bit 3, then a clean 0xF0 frame
        start_frame(8'h5A, 1'b1, PAR_EVEN, 5'd4, 1'b0);
        repeat (17) @(negedge CLK);
        check("mid.bit3", u_if.TX_OUT, 1);
        check("mid.busy", u_if.Busy, 1);
        #2;
        RST = 1'b0;
        #1;
        check("mid_rst.tx_async", u_if.TX_OUT, 1);
        check("mid_rst.busy_async", u_if.Busy, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (u_if.TX_OUT !== 1'b1 || u_if.Busy !== 1'b0) bad++;
        end
        check("mid_rst.idle_errs", bad, 0);
        start_frame(8'hF0, 1'b1, PAR_ODD, 5'd4, 1'b0);
        check_frame("fF0", 8'hF0, 1'b1, PAR_ODD, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
